// File: rtl/plru_repl_unit.sv
// Tree pseudo-LRU replacement unit: WAYS-1 tree bits per set, one op per cycle, one-hot response a cycle later.
// Optional PLRU_WAY_LOCK_EN adds a lock_mask input that excludes ways from victim selection.
module plru_repl_unit #(
    parameter int WAYS = 4,
    parameter int SETS = 64,
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic [1:0]       req_op,
    input  logic [WAYS-1:0]  req_way,
    input  logic [WAYS-1:0]  req_line_valid,
`ifdef PLRU_WAY_LOCK_EN
    input  logic [WAYS-1:0]  lock_mask,
`endif
    output logic             resp_valid,
    output logic [WAYS-1:0]  resp_way,
    output logic             resp_err,
    output logic             init_busy
);

    localparam int LVL = $clog2(WAYS);

    typedef logic [WAYS-2:0] tree_t;
    typedef enum logic [1:0] {OP_HIT = 2'b00, OP_ALLOC = 2'b01, OP_PROBE = 2'b10, OP_INVAL = 2'b11} op_e;
    typedef enum logic {S_INIT, S_RUN} state_e;

    // Walk root-to-leaf for way; toward=0 points every node away (touch), toward=1 points at it (demote).
    function automatic tree_t set_path(input tree_t bits, input logic [LVL-1:0] way, input logic toward);
        tree_t b;
        int    node;
        logic  dir;
        b    = bits;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            dir     = way[LVL-1-l];
            b[node] = toward ? dir : ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return b;
    endfunction

    function automatic logic [LVL-1:0] tree_victim(input tree_t bits);
        int node;
        node = 0;
        for (int l = 0; l < LVL; l++)
            node = 2 * node + 1 + int'(bits[node]);
        return LVL'(node - (WAYS - 1));
    endfunction

    function automatic logic [LVL-1:0] onehot_idx(input logic [WAYS-1:0] oh);
        logic [LVL-1:0] idx;
        idx = '0;
        for (int i = 0; i < WAYS; i++)
            if (oh[i]) idx = LVL'(i);
        return idx;
    endfunction

    function automatic logic [WAYS-1:0] lowest_set(input logic [WAYS-1:0] x);
        return x & (~x + 1'b1);
    endfunction

    state_e          state_q, state_d;
    logic [SET_W-1:0] sweep_cnt;
    tree_t           tree_q [SETS];

    logic            accept;
    logic [WAYS-1:0] lock_eff;
    tree_t           cur_bits, upd_bits;
    logic            upd_en;
    logic [WAYS-1:0] sel_way;
    logic            sel_err;
    logic [WAYS-1:0] victim, tv_oh, cand_inv;
    logic            way_ok;

`ifdef PLRU_WAY_LOCK_EN
    assign lock_eff = lock_mask;
`else
    assign lock_eff = '0;
`endif

    assign accept = req_valid && req_ready && !reset;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && sweep_cnt == SET_W'(SETS - 1))
            state_d = S_RUN;
    end

    always_comb begin
        init_busy = (state_q == S_INIT);
        req_ready = (state_q == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset)                 sweep_cnt <= '0;
        else if (state_q == S_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end

    // NOTE: the tree array has no reset; the post-reset sweep clears it one set per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) tree_q[sweep_cnt] <= '0;
        else if (upd_en)       tree_q[req_set]   <= upd_bits;
    end

    // Victim: lowest unlocked invalid way, else tree victim, else lowest unlocked way.
    always_comb begin
        cur_bits = tree_q[req_set];
        way_ok   = (req_way != '0) && ((req_way & (req_way - 1'b1)) == '0);
        cand_inv = ~req_line_valid & ~lock_eff;
        tv_oh    = '0;
        tv_oh[tree_victim(cur_bits)] = 1'b1;
        if (cand_inv != '0)              victim = lowest_set(cand_inv);
        else if ((tv_oh & lock_eff) == '0) victim = tv_oh;
        else                             victim = lowest_set(~lock_eff);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        upd_bits = cur_bits;
        upd_en   = 1'b0;
        sel_way  = '0;
        sel_err  = 1'b0;
        case (op_e'(req_op))
            OP_HIT, OP_INVAL: begin
                if (way_ok) begin
                    sel_way  = req_way;
                    upd_bits = set_path(cur_bits, onehot_idx(req_way), req_op == OP_INVAL);
                    upd_en   = accept;
                end else begin
                    sel_err = 1'b1;
                end
            end
            default: begin
                if (victim == '0) begin
                    sel_err = 1'b1;
                end else begin
                    sel_way  = victim;
                    upd_bits = set_path(cur_bits, onehot_idx(victim), 1'b0);
                    upd_en   = accept && (req_op == OP_ALLOC);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_way <= sel_way;
                resp_err <= sel_err;
            end
        end
    end

endmodule
